// File: rtl/risc_pkg.sv
// Shared types and constants for the fetch stage: FSM encoding, NOP word and default vectors.
package risc_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    ISSUE    = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection: sequential, redirect target, or trap vector on misalignment.
module next_pc_gen
  import risc_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = DEFAULT_TRAP_PC
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    misalign = 1'b0;
    next_pc  = pc + 32'd4;
    if (redirect) begin
      if (is_word_aligned(target)) begin
        next_pc = target;
      end else begin
        next_pc  = TRAP_PC;
        misalign = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, runs one req/gnt/rvalid transaction at a time and
// holds the fetched instruction until execute signals completion.
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_i,
  input  logic        jump_ctl_i,
  input  logic [31:0] target_addr_i,
  input  logic        exec_done_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o,
  output logic [31:0] mepc_o
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  mepc_reg;
  logic         misalign_reg;
  logic [31:0]  npc;
  logic         npc_misalign;
  logic         exec_fire;

  next_pc_gen #(
    .TRAP_PC (TRAP_PC)
  ) u_next_pc_gen (
    .pc       (pc_reg),
    .redirect (jump_ctl_i | branch_taken_i),
    .target   (target_addr_i),
    .next_pc  (npc),
    .misalign (npc_misalign)
  );

  assign exec_fire = (state_reg == ISSUE) && exec_done_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:     state_next = REQ;
      REQ:      if (imem_gnt_i)    state_next = WAIT_RSP;
      WAIT_RSP: if (imem_rvalid_i) state_next = ISSUE;
      ISSUE:    if (exec_done_i)   state_next = REQ;
      default:  state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP_INSTR;
      mepc_reg     <= 32'd0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Fault flag is recomputed every cycle so it can only ever be a single-cycle pulse.
      misalign_reg <= exec_fire && npc_misalign;
      if (exec_fire) begin
        pc_reg <= npc;
      end
      if (exec_fire && npc_misalign) begin
        mepc_reg <= pc_reg;
      end
      if ((state_reg == WAIT_RSP) && imem_rvalid_i) begin
        instr_reg <= imem_rdata_i;
      end
    end
  end

  assign imem_req_o    = (state_reg == REQ);
  assign imem_addr_o   = pc_reg;
  assign instr_valid_o = (state_reg == ISSUE);
  assign instr_o       = instr_reg;
  assign pc_o          = pc_reg;
  assign pc_plus4_o    = pc_reg + 32'd4;
  assign misalign_o    = misalign_reg;
  assign mepc_o        = mepc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected request addresses, instructions
// and fault PCs into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_fetch_unit;

  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken_i = 1'b0;
  logic        jump_ctl_i = 1'b0;
  logic [31:0] target_addr_i = 32'd0;
  logic        exec_done_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misalign_o;
  logic [31:0] mepc_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_q[$];
  logic [63:0] instr_q[$];
  logic [31:0] mepc_q[$];

  logic [31:0] cur_pc;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TRAP_PC  (TRAP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .branch_taken_i (branch_taken_i),
    .jump_ctl_i     (jump_ctl_i),
    .target_addr_i  (target_addr_i),
    .exec_done_i    (exec_done_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .misalign_o     (misalign_o),
    .mepc_o         (mepc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_mis = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_req_o) begin
          if (!prev_req) begin
            if (addr_q.size() == 0) fail_evt("req_unexpected");
            else chk("req_addr", imem_addr_o, addr_q.pop_front());
          end else begin
            chk("req_addr_stable", imem_addr_o, prev_addr);
          end
        end
        if (instr_valid_o && !prev_valid) begin
          if (instr_q.size() == 0) fail_evt("valid_unexpected");
          else begin
            e = instr_q.pop_front();
            chk("issue_pc", pc_o, e[63:32]);
            chk("issue_instr", instr_o, e[31:0]);
          end
        end
        if (misalign_o) begin
          if (prev_mis) fail_evt("misalign_width");
          else if (mepc_q.size() == 0) fail_evt("misalign_unexpected");
          else begin
            chk("mepc", mepc_o, mepc_q.pop_front());
            chk("trap_pc", pc_o, TRAP);
          end
        end
      end
      prev_req   = imem_req_o && !reset;
      prev_valid = instr_valid_o && !reset;
      prev_mis   = misalign_o && !reset;
      prev_addr  = imem_addr_o;
    end
  end

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = imem_req_o;
    if (!ok) fail_evt("req_timeout");
  endtask

  task automatic fetch(input logic [31:0] rdata, input int gnt_wait, input bit spurious,
                       input bit early_exec);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < gnt_wait; i++) begin
      imem_rvalid_i = spurious;
      imem_rdata_i  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      imem_rvalid_i = 1'b0;
      chk("bp_req_held", {31'd0, imem_req_o}, 32'd1);
      chk("spurious_rvalid", instr_o, last_instr);
    end
    imem_gnt_i = 1'b1;
    @(posedge clk); #1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = rdata;
    if (early_exec) begin
      exec_done_i   = 1'b1;
      jump_ctl_i    = 1'b1;
      target_addr_i = 32'h0000_0080;
    end
    instr_q.push_back({cur_pc, rdata});
    @(posedge clk); #1;
    imem_rvalid_i = 1'b0;
    exec_done_i   = 1'b0;
    jump_ctl_i    = 1'b0;
    target_addr_i = 32'd0;
    last_instr    = rdata;
    if (gnt_wait == 0) chk("valid_latency", {31'd0, instr_valid_o}, 32'd1);
  endtask

  task automatic exec(input bit br, input bit jmp, input logic [31:0] target);
    logic [31:0] np;
    int n = 0;
    while (!instr_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_valid_o) begin
      fail_evt("valid_timeout");
      return;
    end
    branch_taken_i = br;
    jump_ctl_i     = jmp;
    target_addr_i  = target;
    exec_done_i    = 1'b1;
    if (!(br || jmp)) np = cur_pc + 32'd4;
    else if (target[1:0] == 2'b00) np = target;
    else begin
      np = TRAP;
      mepc_q.push_back(cur_pc);
    end
    addr_q.push_back(np);
    cur_pc = np;
    @(posedge clk); #1;
    branch_taken_i = 1'b0;
    jump_ctl_i     = 1'b0;
    target_addr_i  = 32'd0;
    exec_done_i    = 1'b0;
    chk("valid_drop", {31'd0, instr_valid_o}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_instr"}, instr_o, NOP);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    chk({tag, "_mepc"}, mepc_o, 32'd0);
  endtask

  initial begin
    bit ok;
    cur_pc     = 32'd0;
    last_instr = NOP;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    addr_q.push_back(32'd0);
    chk("boot_idle", {31'd0, imem_req_o}, 32'd0);
    @(posedge clk); #1;
    chk("boot_req", {31'd0, imem_req_o}, 32'd1);

    fetch(32'h0050_0093, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b1, 32'h0000_0010);
    // exec_done during WAIT_RSP must be ignored
    fetch(32'h0010_0113, 0, 1'b0, 1'b1);
    exec(1'b0, 1'b0, 32'h0000_0000);
    chk("seq_pc", pc_o, 32'h0000_0014);
    chk("seq_pc_plus4", pc_plus4_o, 32'h0000_0018);
    fetch(32'h00C0_006F, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b1, 32'h0000_0020);
    fetch(32'h0220_8063, 0, 1'b0, 1'b0);
    exec(1'b1, 1'b0, 32'h0000_0040);
    chk("branch_no_misalign", {31'd0, misalign_o}, 32'd0);
    fetch(32'hFF1F_F06F, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b1, 32'h0000_0030);
    fetch(32'h0120_006F, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b1, 32'h0000_0042);
    chk("misalign_pulse", {31'd0, misalign_o}, 32'd1);
    chk("misalign_mepc", mepc_o, 32'h0000_0030);
    fetch(32'h3420_2573, 5, 1'b1, 1'b0);
    exec(1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b0, 32'h0000_0000);
    chk("wrap_pc", pc_o, 32'h0000_0000);

    // Reset asserted mid-cycle while in WAIT_RSP
    wait_req(ok);
    if (ok) begin
      imem_gnt_i = 1'b1;
      @(posedge clk); #1;
      imem_gnt_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
    end
    @(posedge clk); #1;
    reset      = 1'b0;
    cur_pc     = 32'd0;
    last_instr = NOP;
    addr_q.push_back(32'd0);
    fetch(32'h0070_0193, 0, 1'b0, 1'b0);
    exec(1'b0, 1'b0, 32'h0000_0000);
    wait_req(ok);
    repeat (3) @(posedge clk);
    #1;
    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("instr_q_drained", instr_q.size(), 32'd0);
    chk("mepc_q_drained", mepc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural PC and fetches instructions from instruction memory over a req/gnt/rvalid handshake.
- Presents one instruction at a time to decode/execute.
- On execute completion, consumes branch_taken_o from branch_control plus the jump control and ALU target to select the next PC.
- Redirects to a trap vector when a taken target is misaligned.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned-target fault.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch_taken_i  input  1  branch outcome from branch_control.
- jump_ctl_i  input  1  current instruction is JAL/JALR.
- target_addr_i  input  32  branch/jump target computed by the ALU.
- exec_done_i  input  1  execute has consumed instr_o; next-PC inputs are valid this cycle.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address, always equals pc_o.
- imem_gnt_i  input  1  request accepted.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  read data.
- instr_o  output  32  registered instruction.
- instr_valid_o  output  1  instr_o valid for execute.
- pc_o  output  32  PC of the current instruction.
- pc_plus4_o  output  32  pc_o + 4, used as the link value.
- misalign_o  output  1  one-cycle pulse on a misaligned target fault.
- mepc_o  output  32  PC of the faulting instruction.

Behaviour:
- Reset (asynchronous, immediate):
  - pc_o = RESET_PC; instr_o = NOP_INSTR (32'h0000_0013).
  - instr_valid_o = 0, imem_req_o = 0, misalign_o = 0, mepc_o = 0.
  - FSM to BOOT.
- FSM states BOOT, REQ, WAIT_RSP, ISSUE:
  - BOOT: one idle cycle after reset deasserts, then go to REQ.
  - REQ: imem_req_o = 1, imem_addr_o = pc_o. imem_gnt_i = 1 moves to WAIT_RSP; otherwise hold the request and address stable.
  - WAIT_RSP: imem_req_o = 0. imem_rvalid_i = 1 latches imem_rdata_i into instr_o and moves to ISSUE.
  - ISSUE: instr_valid_o = 1 and instr_o is held stable. exec_done_i = 1 updates the PC (rule below), drops instr_valid_o the next cycle, and moves to REQ.
- Next-PC selection, evaluated only when exec_done_i = 1 in ISSUE:
  - redirect = jump_ctl_i | branch_taken_i.
  - redirect = 0: pc <= pc_o + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - redirect = 1 and target_addr_i[1:0] == 0: pc <= target_addr_i.
  - redirect = 1 and target_addr_i[1:0] != 0: pc <= TRAP_PC, mepc_o <= pc_o, misalign_o = 1 for exactly one cycle.
  - branch_taken_i alone is honoured; upstream already gates it with B-type decode.
- Latency: if gnt arrives in the REQ entry cycle and rvalid the next cycle, instr_valid_o rises 2 cycles after REQ entry. After reset deassert, the first request appears at cycle 2.
- Ignored events:
  - imem_rvalid_i outside WAIT_RSP.
  - imem_gnt_i outside REQ.
  - exec_done_i outside ISSUE.
- imem_rvalid_i in the same cycle as gnt is illegal; the memory guarantees rvalid no earlier than the cycle after gnt.
- One outstanding request at most.
- Reset mid-fetch: any outstanding transaction is abandoned. The memory shares the same reset, so no stale rvalid returns.
- pc_plus4_o is combinational from pc_o.

Decomposition:
- risc_pkg additions:
  - fetch_state_t enum {BOOT, REQ, WAIT_RSP, ISSUE}.
  - NOP_INSTR constant.
  - Default RESET_PC / TRAP_PC localparams.
- One combinational sub-module, next_pc_gen:
  - Inputs: pc, redirect, target.
  - Outputs: next_pc, misalign.
- FSM, PC register and instruction register stay in fetch_unit.

Test Plan:
- Boot: assert reset, then release → pc_o = 0, imem_req_o rises at cycle 2 with addr 0. Return gnt immediately and rvalid next cycle with 32'h00500093 → instr_o = 32'h00500093, instr_valid_o = 1.
- Sequential: exec_done_i with no redirect at pc 0x10 → next request addr 0x14, pc_plus4_o = 0x18 after update.
- Taken branch: branch_taken_i = 1, target 0x40 at pc 0x20 → next imem_addr_o = 0x40, misalign_o stays 0.
- Misaligned jump: jump_ctl_i = 1, target 0x42 at pc 0x30 → pc = 0x100, mepc_o = 0x30, misalign_o high for exactly one cycle.
- Backpressure: hold imem_gnt_i = 0 for 5 cycles → imem_req_o and imem_addr_o stable throughout; a spurious rvalid during REQ is ignored (instr_o unchanged).
- Wrap / async reset: pc 0xFFFF_FFFC with no redirect → next addr 0. Assert reset during WAIT_RSP → outputs return to reset values in the same cycle, not waiting for a clock edge.
